// File: rtl/pio_in_pkg.sv
// Shared definitions for the debounced edge-capture input PIO:
// register word addresses and the Avalon data-bus width.
package pio_in_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RAW          = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd5;
    localparam logic [2:0] ADDR_DEBOUNCE     = 3'd6;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, runtime-length debounce counter and
// stable/stable_d flops used by the parent for edge detection.
module pio_debounce_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_bit,
    input  logic [DB_WIDTH-1:0] debounce,
    output logic                sync,
    output logic                stable,
    output logic                stable_d
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DB_WIDTH-1:0]    cnt_reg;
    logic                   stable_reg;
    logic                   stable_d_reg;

    assign sync     = sync_reg[SYNC_STAGES-1];
    assign stable   = stable_reg;
    assign stable_d = stable_d_reg;

    // ">=" rather than "==" so lowering debounce mid-count commits promptly
    // and the counter can never wrap past the threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg     <= '0;
            cnt_reg      <= '0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], in_bit};
            stable_d_reg <= stable_reg;
            if (sync == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg >= debounce) begin
                stable_reg <= sync;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_in_edge_debounce.sv
// Avalon-MM input PIO with per-bit synchroniser, debounce filter, selectable
// rising/falling edge capture (write-1-to-clear) and a masked interrupt.
module pio_in_edge_debounce
    import pio_in_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          DB_WIDTH    = 16,
    parameter int unsigned DB_RESET    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0]    irq_mask_reg;
    logic [WIDTH-1:0]    edge_capture_reg;
    logic [WIDTH-1:0]    edge_capture_next;
    logic [WIDTH-1:0]    rise_en_reg;
    logic [WIDTH-1:0]    fall_en_reg;
    logic [DB_WIDTH-1:0] debounce_reg;
    logic [DATA_W-1:0]   readdata_reg;
    logic [DATA_W-1:0]   readdata_next;

    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] stable_bits;
    logic [WIDTH-1:0] stable_d_bits;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] ec_clear;
    logic             wr_en;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce_bit #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_WIDTH    (DB_WIDTH)
            ) u_bit (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_bit   (in_port[gi]),
                .debounce (debounce_reg),
                .sync     (sync_bits[gi]),
                .stable   (stable_bits[gi]),
                .stable_d (stable_d_bits[gi])
            );
        end
    endgenerate

    assign wr_en    = chipselect && !write_n;
    assign edge_hit = (stable_bits & ~stable_d_bits & rise_en_reg)
                    | (~stable_bits & stable_d_bits & fall_en_reg);
    assign ec_clear = (wr_en && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

    // A new edge is OR-ed in after the clear so a coincident event is never lost.
    assign edge_capture_next = (edge_capture_reg & ~ec_clear) | edge_hit;

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:         readdata_next[WIDTH-1:0]    = stable_bits;
            ADDR_RAW:          readdata_next[WIDTH-1:0]    = sync_bits;
            ADDR_IRQ_MASK:     readdata_next[WIDTH-1:0]    = irq_mask_reg;
            ADDR_EDGE_CAPTURE: readdata_next[WIDTH-1:0]    = edge_capture_reg;
            ADDR_RISE_EN:      readdata_next[WIDTH-1:0]    = rise_en_reg;
            ADDR_FALL_EN:      readdata_next[WIDTH-1:0]    = fall_en_reg;
            ADDR_DEBOUNCE:     readdata_next[DB_WIDTH-1:0] = debounce_reg;
            default:           readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
            rise_en_reg      <= '1;
            fall_en_reg      <= '1;
            debounce_reg     <= DB_WIDTH'(DB_RESET);
            readdata_reg     <= '0;
        end else begin
            edge_capture_reg <= edge_capture_next;
            readdata_reg     <= readdata_next;
            if (wr_en) begin
                case (address)
                    ADDR_IRQ_MASK: irq_mask_reg <= writedata[WIDTH-1:0];
                    ADDR_RISE_EN:  rise_en_reg  <= writedata[WIDTH-1:0];
                    ADDR_FALL_EN:  fall_en_reg  <= writedata[WIDTH-1:0];
                    ADDR_DEBOUNCE: debounce_reg <= writedata[DB_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_pio_in_edge_debounce.sv
// Directed bench: an 8-bit instance and a 32-bit/3-stage instance share the bus;
// expected values are hand-computed from the register and latency rules.
module tb_pio_in_edge_debounce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in8;
    logic [31:0] in32;
    logic [31:0] rd8;
    logic [31:0] rd32;
    logic        irq8;
    logic        irq32;

    logic [31:0] rd8_s;
    logic [31:0] rd32_s;
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pio_in_edge_debounce #(.WIDTH(8), .SYNC_STAGES(2), .DB_WIDTH(16), .DB_RESET(0)) dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in8),
        .readdata(rd8), .irq(irq8)
    );

    pio_in_edge_debounce #(.WIDTH(32), .SYNC_STAGES(3), .DB_WIDTH(16), .DB_RESET(5)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in32),
        .readdata(rd32), .irq(irq32)
    );

    task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        address = a;
        tick();
        rd8_s  = rd8;
        rd32_s = rd32;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in8        = '0;
        in32       = '0;
        tick();
        check_equal("reset_readdata8", rd8, 32'h0);
        check_equal("reset_irq8", {31'b0, irq8}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: reset defaults on both instances
        bus_read(3'd2); check_equal("rst_mask8", rd8_s, 32'h0);  check_equal("rst_mask32", rd32_s, 32'h0);
        bus_read(3'd3); check_equal("rst_ec8", rd8_s, 32'h0);    check_equal("rst_ec32", rd32_s, 32'h0);
        bus_read(3'd4); check_equal("rst_rise8", rd8_s, 32'hFF); check_equal("rst_rise32", rd32_s, 32'hFFFF_FFFF);
        bus_read(3'd5); check_equal("rst_fall8", rd8_s, 32'hFF); check_equal("rst_fall32", rd32_s, 32'hFFFF_FFFF);
        bus_read(3'd6); check_equal("rst_db8", rd8_s, 32'h0);    check_equal("rst_db32", rd32_s, 32'h5);
        bus_read(3'd7); check_equal("addr7_8", rd8_s, 32'h0);
        check_equal("rst_irq8", {31'b0, irq8}, 32'h0);
        check_equal("rst_irq32", {31'b0, irq32}, 32'h0);

        // 2: step latency with DEBOUNCE=3 (stable at edge 6, capture at edge 7)
        bus_write(3'd6, 32'h3);
        bus_write(3'd2, 32'h1);
        address = 3'd0;
        tick();
        in8[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                check_equal("step_data_e6", {31'b0, rd8[0]}, 32'h0);
                check_equal("step_irq_e6", {31'b0, irq8}, 32'h0);
            end
            if (k == 7) begin
                check_equal("step_data_e7", {31'b0, rd8[0]}, 32'h1);
                check_equal("step_irq_e7", {31'b0, irq8}, 32'h1);
            end
        end
        bus_read(3'd3); check_equal("step_ec", rd8_s, 32'h01);

        // 3: 3-cycle glitch filtered, 4-cycle pulse rises and falls
        bus_write(3'd3, 32'hFF);
        check_equal("clear_irq", {31'b0, irq8}, 32'h0);
        in8[1] = 1'b1;
        repeat (3) tick();
        in8[1] = 1'b0;
        repeat (15) tick();
        bus_read(3'd0); check_equal("glitch_data", rd8_s, 32'h01);
        bus_read(3'd3); check_equal("glitch_ec", rd8_s, 32'h00);
        in8[1] = 1'b1;
        repeat (4) tick();
        in8[1] = 1'b0;
        repeat (20) tick();
        bus_read(3'd0); check_equal("pulse4_data", rd8_s, 32'h01);
        bus_read(3'd3); check_equal("pulse4_ec", rd8_s, 32'h02);

        // 4: edge select, bit 2 falling only
        bus_write(3'd4, 32'h00);
        bus_write(3'd5, 32'h04);
        bus_write(3'd3, 32'hFF);
        in8[2] = 1'b1;
        repeat (20) tick();
        bus_read(3'd0); check_equal("sel_rise_data", rd8_s, 32'h05);
        bus_read(3'd3); check_equal("sel_rise_ec", rd8_s, 32'h00);
        in8[2] = 1'b0;
        repeat (20) tick();
        bus_read(3'd3); check_equal("sel_fall_ec", rd8_s, 32'h04);
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_write(3'd5, 32'hFFFF_FFFF);

        // 5: set wins over coincident clear
        bus_write(3'd3, 32'hFF);
        in8[1] = 1'b1;
        repeat (20) tick();
        bus_read(3'd3); check_equal("w1c_setup_b1", rd8_s, 32'h02);
        in8[0] = 1'b0;
        repeat (20) tick();
        bus_read(3'd3); check_equal("w1c_setup_b01", rd8_s, 32'h03);
        bus_read(3'd1); check_equal("raw_data", rd8_s, 32'h02);
        tick();
        in8[0] = 1'b1;
        repeat (6) tick();
        bus_write(3'd3, 32'h01);
        bus_read(3'd3); check_equal("w1c_set_wins", rd8_s, 32'h03);
        bus_write(3'd3, 32'h02);
        bus_read(3'd3); check_equal("w1c_bit1", rd8_s, 32'h01);

        // 6: 32-bit instance, lower DEBOUNCE mid-count, then async reset mid-access
        bus_write(3'd6, 32'hFFFF);
        bus_write(3'd2, 32'h8000_0000);
        in32[31] = 1'b1;
        repeat (10) tick();
        bus_write(3'd6, 32'h2);
        check_equal("lower_irq_w", {31'b0, irq32}, 32'h0);
        tick();
        check_equal("lower_irq_w1", {31'b0, irq32}, 32'h0);
        tick();
        check_equal("lower_irq_w2", {31'b0, irq32}, 32'h1);
        bus_read(3'd0); check_equal("lower_data32", rd32_s, 32'h8000_0000);

        address    = 3'd2;
        writedata  = 32'hFFFF_FFFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_equal("async_irq32", {31'b0, irq32}, 32'h0);
        check_equal("async_rd32", rd32, 32'h0);
        check_equal("async_irq8", {31'b0, irq8}, 32'h0);
        in8  = '0;
        in32 = '0;
        tick();
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        bus_read(3'd2); check_equal("post_mask32", rd32_s, 32'h0); check_equal("post_mask8", rd8_s, 32'h0);
        bus_read(3'd3); check_equal("post_ec32", rd32_s, 32'h0);
        bus_read(3'd4); check_equal("post_rise32", rd32_s, 32'hFFFF_FFFF);
        bus_read(3'd6); check_equal("post_db32", rd32_s, 32'h5); check_equal("post_db8", rd8_s, 32'h0);
        check_equal("post_irq32", {31'b0, irq32}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
